// File: rtl/sarray_param.sv
// sarray_param: output-stationary ROWS x COLS systolic multiply-accumulate array.
//
// Each PE forwards its left operand one column to the right and its top
// operand one row down, with one register per hop. When both operands at a PE
// are valid, the product is added into that PE's accumulator. The caller
// supplies the operand skew.
//
// A drain pulse ends the tile. The FSM then flushes the pipeline for
// ROWS+COLS-1 cycles. After that it streams one row of accumulators per cycle
// for ROWS cycles, and it clears every accumulator on the final row.
//
// Build option: define SARRAY_PARAM_SAT_EN to make accumulation saturate at
// the signed AW-bit limits. Without it, accumulation wraps modulo 2^AW.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   a_valid_i/a_data_i  per-row left-edge operands (row r at [r*DW +: DW])
//   b_valid_i/b_data_i  per-column top-edge operands (col c at [c*DW +: DW])
//   clear_i             zero all accumulators (honoured in IDLE/RUN only)
//   drain_i             end of tile: flush, then stream results
//   busy_o              high while flushing or draining; edge operands ignored
//   out_valid_o         result row valid
//   out_row_o           index of the row on out_data_o
//   out_data_o          accumulators of that row (col c at [c*AW +: AW])
module sarray_param #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 8,
  parameter int AW   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ROWS-1:0]           a_valid_i,
  input  logic [ROWS*DW-1:0]        a_data_i,
  input  logic [COLS-1:0]           b_valid_i,
  input  logic [COLS*DW-1:0]        b_data_i,
  input  logic                      clear_i,
  input  logic                      drain_i,
  output logic                      busy_o,
  output logic                      out_valid_o,
  output logic [$clog2(ROWS)-1:0]   out_row_o,
  output logic [COLS*AW-1:0]        out_data_o
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS + COLS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [CW-1:0] FLUSH_LAST = CW'(ROWS + COLS - 2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(ROWS - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [RW-1:0] ROW_ONE    = RW'(1);

  // Adds a sign-extended product into an accumulator, saturating or wrapping
  // depending on the build.
  function automatic logic signed [AW-1:0] acc_add(input logic signed [AW-1:0] acc,
                                                   input logic signed [2*DW-1:0] prod);
`ifdef SARRAY_PARAM_SAT_EN
    logic signed [AW:0] sum;
    sum = (AW+1)'(acc) + (AW+1)'(prod);
    if (sum[AW] != sum[AW-1]) begin
      acc_add = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else begin
      acc_add = sum[AW-1:0];
    end
`else
    acc_add = acc + AW'(prod);
`endif
  endfunction

  logic [1:0]    state_r, state_nx;
  logic [CW-1:0] cnt_r, cnt_nx;
  logic [RW-1:0] row_nx;
  logic          edge_ok_s, clr_s, drain_done_s;

  // Horizontal links exist only between columns, and vertical links only
  // between rows. Registers after the last column or the last row would feed
  // nothing, so none are built there.
  logic [ROWS*(COLS-1)-1:0]    av_s;
  logic [ROWS*(COLS-1)*DW-1:0] ad_s;
  logic [(ROWS-1)*COLS-1:0]    bv_s;
  logic [(ROWS-1)*COLS*DW-1:0] bd_s;
  logic [ROWS*COLS*AW-1:0]     acc_s;

  assign edge_ok_s    = (state_r == ST_IDLE) || (state_r == ST_RUN);
  assign clr_s        = clear_i & edge_ok_s;
  assign drain_done_s = (state_r == ST_DRAIN) && (cnt_r == DRAIN_LAST);

  // Next-state and phase counter; the counter times both FLUSH and DRAIN.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (drain_i) begin
          state_nx = ST_FLUSH;
          cnt_nx   = {CW{1'b0}};
        end else if ((|a_valid_i) || (|b_valid_i)) begin
          state_nx = ST_RUN;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (drain_i) begin
          state_nx = ST_FLUSH;
          cnt_nx   = {CW{1'b0}};
        end else begin
          state_nx = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (cnt_r == FLUSH_LAST) begin
          state_nx = ST_DRAIN;
          cnt_nx   = {CW{1'b0}};
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end
      ST_DRAIN: begin
        if (cnt_r == DRAIN_LAST) begin
          state_nx = ST_IDLE;
          cnt_nx   = {CW{1'b0}};
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = {CW{1'b0}};
      end
    endcase
  end

  // Row shown in the next cycle: row 0 on DRAIN entry, then one up per cycle.
  always_comb begin
    if (state_r == ST_DRAIN) begin
      row_nx = cnt_r[RW-1:0] + ROW_ONE;
    end else begin
      row_nx = {RW{1'b0}};
    end
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CW{1'b0}};
      busy_o      <= 1'b0;
      out_valid_o <= 1'b0;
      out_row_o   <= {RW{1'b0}};
      out_data_o  <= {(COLS*AW){1'b0}};
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      busy_o  <= (state_nx == ST_FLUSH) || (state_nx == ST_DRAIN);
      if (state_nx == ST_DRAIN) begin
        out_valid_o <= 1'b1;
        out_row_o   <= row_nx;
        out_data_o  <= acc_s[row_nx*COLS*AW +: COLS*AW];
      end else begin
        out_valid_o <= 1'b0;
        out_row_o   <= {RW{1'b0}};
        out_data_o  <= {(COLS*AW){1'b0}};
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic                   pa_v, pb_v, mac_s;
      logic signed [DW-1:0]   pa_d, pb_d;
      logic signed [2*DW-1:0] prod_s;
      logic signed [AW-1:0]   acc_r;

      if (c == 0) begin : g_left
        assign pa_v = a_valid_i[r] & edge_ok_s;
        assign pa_d = a_data_i[r*DW +: DW];
      end else begin : g_from_left
        assign pa_v = av_s[r*(COLS-1)+c-1];
        assign pa_d = ad_s[(r*(COLS-1)+c-1)*DW +: DW];
      end

      if (r == 0) begin : g_top
        assign pb_v = b_valid_i[c] & edge_ok_s;
        assign pb_d = b_data_i[c*DW +: DW];
      end else begin : g_from_top
        assign pb_v = bv_s[(r-1)*COLS+c];
        assign pb_d = bd_s[((r-1)*COLS+c)*DW +: DW];
      end

      assign mac_s  = pa_v & pb_v;
      assign prod_s = (2*DW)'(pa_d) * (2*DW)'(pb_d);
      assign acc_s[(r*COLS+c)*AW +: AW] = acc_r;

      if (c < COLS-1) begin : g_a_reg
        logic                 av_r;
        logic signed [DW-1:0] ad_r;
        // Left operand hop to the next column.
        always_ff @(posedge clk) begin
          if (rst) begin
            av_r <= 1'b0;
            ad_r <= {DW{1'b0}};
          end else begin
            av_r <= pa_v;
            ad_r <= pa_d;
          end
        end
        assign av_s[r*(COLS-1)+c]          = av_r;
        assign ad_s[(r*(COLS-1)+c)*DW +: DW] = ad_r;
      end

      if (r < ROWS-1) begin : g_b_reg
        logic                 bv_r;
        logic signed [DW-1:0] bd_r;
        // Top operand hop to the next row.
        always_ff @(posedge clk) begin
          if (rst) begin
            bv_r <= 1'b0;
            bd_r <= {DW{1'b0}};
          end else begin
            bv_r <= pb_v;
            bd_r <= pb_d;
          end
        end
        assign bv_s[r*COLS+c]          = bv_r;
        assign bd_s[(r*COLS+c)*DW +: DW] = bd_r;
      end

      // Accumulator. A clear that coincides with a MAC loads the fresh product.
      always_ff @(posedge clk) begin
        if (rst) begin
          acc_r <= {AW{1'b0}};
        end else if (drain_done_s) begin
          acc_r <= {AW{1'b0}};
        end else if (clr_s) begin
          acc_r <= mac_s ? acc_add({AW{1'b0}}, prod_s) : {AW{1'b0}};
        end else if (mac_s) begin
          acc_r <= acc_add(acc_r, prod_s);
        end else begin
          acc_r <= acc_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_sarray_param.sv
// Self-checking bench for sarray_param (4x4, DW=8, AW=16).
module tb_sarray_param;
  localparam int R = 4;
  localparam int C = 4;
  localparam int DW = 8;
  localparam int AW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [R-1:0]    a_valid = '0;
  logic [R*DW-1:0] a_data = '0;
  logic [C-1:0]    b_valid = '0;
  logic [C*DW-1:0] b_data = '0;
  logic            clear = 1'b0;
  logic            drain = 1'b0;
  logic            busy, out_valid;
  logic [1:0]      out_row;
  logic [C*AW-1:0] out_data;

  int checks = 0;
  int failures = 0;
  int A[R][8];
  int B[8][C];
  int model[R][C];

  sarray_param #(.ROWS(R), .COLS(C), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .a_valid_i(a_valid), .a_data_i(a_data),
    .b_valid_i(b_valid), .b_data_i(b_data),
    .clear_i(clear), .drain_i(drain),
    .busy_o(busy), .out_valid_o(out_valid),
    .out_row_o(out_row), .out_data_o(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference accumulation on plain integers.
  function automatic int macc(input int acc, input int p);
    int s;
    logic signed [AW-1:0] t;
    s = acc + p;
`ifdef SARRAY_PARAM_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
`else
    t = s[AW-1:0];
    return int'(t);
`endif
  endfunction

  function automatic logic [63:0] exp_row(input int r);
    logic [63:0] v;
    int t;
    v = '0;
    for (int c = 0; c < C; c++) begin
      t = model[r][c];
      v[c*AW +: AW] = t[AW-1:0];
    end
    return v;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) model[r][c] = 0;
  endtask

  // A matrix product streamed with caller skew. mode: 0 random, 1 ones, 2 twos.
  // Called and returns at a falling edge.
  task automatic run_tile(input int k, input int mode);
    int t;
    int kk;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < k; j++)
        A[i][j] = (mode == 0) ? (int'($urandom_range(255)) - 128) : mode;
    for (int j = 0; j < k; j++)
      for (int c = 0; c < C; c++)
        B[j][c] = (mode == 0) ? (int'($urandom_range(255)) - 128) : mode;
    for (int i = 0; i < R; i++)
      for (int c = 0; c < C; c++)
        for (int j = 0; j < k; j++) model[i][c] = macc(model[i][c], A[i][j] * B[j][c]);
    for (int s = 0; s < k + R + C - 2; s++) begin
      a_valid = '0;
      b_valid = '0;
      for (int i = 0; i < R; i++) begin
        kk = s - i;
        if (kk >= 0 && kk < k) begin
          a_valid[i] = 1'b1;
          t = A[i][kk];
          a_data[i*DW +: DW] = t[DW-1:0];
        end
      end
      for (int c = 0; c < C; c++) begin
        kk = s - c;
        if (kk >= 0 && kk < k) begin
          b_valid[c] = 1'b1;
          t = B[kk][c];
          b_data[c*DW +: DW] = t[DW-1:0];
        end
      end
      @(negedge clk);
    end
    a_valid = '0;
    b_valid = '0;
  endtask

  // Drain at edge t. Checks the busy/out_valid timing and every row's data.
  // With inject set, also pulses drain and clear during FLUSH; both must be
  // ignored.
  task automatic drain_check(input string tag, input bit inject);
    bit ov;
    drain = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= R + C + R; k++) begin
      @(negedge clk);
      drain = (inject && k == 3);
      clear = (inject && k == 4);
      ov = (k >= R + C && k <= R + C + R - 1);
      chk($sformatf("%s_busy_k%0d", tag, k), 64'(busy), 64'(k <= R + C + R - 1));
      chk($sformatf("%s_valid_k%0d", tag, k), 64'(out_valid), 64'(ov));
      chk($sformatf("%s_row_k%0d", tag, k), 64'(out_row), ov ? 64'(k - R - C) : 64'd0);
      chk($sformatf("%s_data_k%0d", tag, k), 64'(out_data), ov ? exp_row(k - R - C) : 64'd0);
    end
    drain = 1'b0;
    clear = 1'b0;
    clear_model();
  endtask

  initial begin
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_row", 64'(out_row), 64'd0);
    chk("reset_data", 64'(out_data), 64'd0);
    rst = 1'b0;

    // Random tile that starts on the first edge after reset, with FLUSH
    // drain/clear pulses that must be ignored.
    run_tile(4, 0);
    drain_check("rand4", 1'b1);

    run_tile(6, 0);
    drain_check("rand6", 1'b0);

    // Tile of ones, then tile of twos: no carry-over between tiles.
    run_tile(4, 1);
    drain_check("ones", 1'b0);
    run_tile(4, 2);
    drain_check("twos", 1'b0);

    // Clear concurrent with a 3*(-4) MAC at PE(0,0) after a junk tile.
    run_tile(4, 0);
    clear_model();
    repeat (8) @(negedge clk);
    a_valid = 4'b0001; a_data = '0; a_data[7:0] = 8'd3;
    b_valid = 4'b0001; b_data = '0; b_data[7:0] = 8'hFC;
    clear = 1'b1;
    @(negedge clk);
    a_valid = '0; b_valid = '0; clear = 1'b0;
    model[0][0] = -12;
    repeat (8) @(negedge clk);
    drain_check("clrmac", 1'b0);

    // 127*127 three times at PE(0,0): wrap or saturate at AW=16.
    a_valid = 4'b0001; a_data = '0; a_data[7:0] = 8'd127;
    b_valid = 4'b0001; b_data = '0; b_data[7:0] = 8'd127;
    repeat (3) @(negedge clk);
    a_valid = '0; b_valid = '0;
    for (int i = 0; i < 3; i++) model[0][0] = macc(model[0][0], 127 * 127);
    repeat (8) @(negedge clk);
    drain_check("sat", 1'b0);

    // Reset during the second DRAIN cycle.
    run_tile(4, 0);
    drain = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= R + C + 1; k++) begin
      @(negedge clk);
      drain = 1'b0;
    end
    chk("middrain_valid", 64'(out_valid), 64'd1);
    chk("middrain_row", 64'(out_row), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstdrain_valid", 64'(out_valid), 64'd0);
    chk("rstdrain_busy", 64'(busy), 64'd0);
    chk("rstdrain_row", 64'(out_row), 64'd0);
    chk("rstdrain_data", 64'(out_data), 64'd0);
    rst = 1'b0;
    clear_model();
    drain_check("empty", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
